// File: rtl/sms_oc_bus_arbiter.sv
// sms_oc_bus_arbiter
//
// Round-robin arbiter for one open-collector, wired-OR SDTRL bus line.
// At most one card group's open-collector driver is enabled at a time. Each
// tenure is framed by a settle window (driver on, data not yet trusted) and
// a recovery window (all drivers off) so the pulled-up line is never fought
// over.
//
// Parameters:
//   N_REQ          number of requesters (2..8)
//   SETTLE_CYCLES  cycles from grant to bus_valid (1..7)
//   RECOVER_CYCLES idle cycles after release before the next grant (1..7)
//   MAX_HOLD       owned cycles before a forced release (2..255); only used
//                  when SMS_ARB_TIMEOUT_EN is defined
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req_n      per-requester request, active-low (only a strict 0 requests)
//   done_n     per-requester release strobe, active-low (strict 0)
//   oc_en      one-hot enable for the owner's open-collector driver
//   bus_valid  owner's data on the bus has settled
//   busy       arbiter is not idle
//   owner      index of the current or most recent owner
//   timeout    one-cycle pulse on a forced release
//
// Optional feature macro: SMS_ARB_TIMEOUT_EN builds an 8-bit hold counter
// and forces a release after MAX_HOLD owned cycles. Without it ownership is
// unbounded and timeout stays 0.
//
// Handshake: a requester holds req_n[i] low until it is granted and keeps it
// low for its whole tenure; it ends the tenure by pulsing done_n[i] low (or by
// dropping req_n[i]) while bus_valid is high. Requests are never latched, so a
// requester that is not granted must keep asserting. All outputs are
// registered.

module sms_oc_bus_arbiter #(
  parameter int N_REQ          = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int RECOVER_CYCLES = 1,
  parameter int MAX_HOLD       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_n,
  input  logic [N_REQ-1:0] done_n,
  output logic [N_REQ-1:0] oc_en,
  output logic             bus_valid,
  output logic             busy,
  output logic [2:0]       owner,
  output logic             timeout
);

  if (N_REQ < 2 || N_REQ > 8 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 7 ||
      RECOVER_CYCLES < 1 || RECOVER_CYCLES > 7 ||
      MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_params
    $error("sms_oc_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_OWN     = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [2:0] SETTLE_LAST  = 3'(SETTLE_CYCLES - 1);
  localparam logic [2:0] RECOVER_LAST = 3'(RECOVER_CYCLES - 1);
  localparam logic [2:0] LAST_IDX     = 3'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [N_REQ-1:0]   oc_en_q, oc_en_d;
  logic               bus_valid_q, bus_valid_d;
  logic               busy_q, busy_d;
  logic [2:0]         owner_q, owner_d;
  logic               timeout_q, timeout_d;

  // Padded to 8 so a 3-bit candidate index always selects a real bit.
  logic [7:0]         req_act;
  logic [N_REQ-1:0]   done_act;
  logic               grant_found;
  logic [2:0]         grant_idx;
  logic [3:0]         cand;
  logic               own_req;
  logic               own_done;
  logic               hold_expired;

`ifdef SMS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  // hold_q counts completed OWN cycles; the edge that would make it reach
  // MAX_HOLD is the forced-release edge.
  assign hold_expired = (hold_q == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  // Pulled-up lines may float to z or x; only a driven 0 counts as active.
  always_comb begin
    req_act  = '0;
    done_act = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_act[i]  = (req_n[i] === 1'b0);
      done_act[i] = (done_n[i] === 1'b0);
    end
  end

  // First active index at or after ptr_q, wrapping. Scanning from the far
  // end down lets the nearest candidate overwrite the others without a break.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    cand        = 4'd0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_q} + 4'(off);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      if (req_act[cand[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  // oc_en_q is one-hot on the owner during a tenure, so it doubles as the
  // owner mask; non-owner done_n/req_n bits are ignored.
  assign own_req  = |(req_act[N_REQ-1:0] & oc_en_q);
  assign own_done = |(done_act & oc_en_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    oc_en_d     = oc_en_q;
    bus_valid_d = bus_valid_q;
    busy_d      = busy_q;
    owner_d     = owner_q;
    timeout_d   = 1'b0;
`ifdef SMS_ARB_TIMEOUT_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d = ST_SETTLE;
          oc_en_d = N_REQ'(8'b1 << grant_idx);
          owner_d = grant_idx;
          ptr_d   = (grant_idx == LAST_IDX) ? 3'd0 : grant_idx + 3'd1;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d     = ST_OWN;
          bus_valid_d = 1'b1;
`ifdef SMS_ARB_TIMEOUT_EN
          hold_d      = 8'd0;
`endif
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_OWN: begin
`ifdef SMS_ARB_TIMEOUT_EN
        hold_d = hold_q + 8'd1;
`endif
        if (own_done || !own_req || hold_expired) begin
          state_d     = ST_RELEASE;
          oc_en_d     = '0;
          bus_valid_d = 1'b0;
          timeout_d   = hold_expired;
          cnt_d       = 3'd0;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == RECOVER_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        oc_en_d     = '0;
        bus_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Reset drops every driver enable at once; no release window is run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd0;
      cnt_q       <= 3'd0;
      oc_en_q     <= '0;
      bus_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 3'd0;
      timeout_q   <= 1'b0;
`ifdef SMS_ARB_TIMEOUT_EN
      hold_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      oc_en_q     <= oc_en_d;
      bus_valid_q <= bus_valid_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      timeout_q   <= timeout_d;
`ifdef SMS_ARB_TIMEOUT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign oc_en     = oc_en_q;
  assign bus_valid = bus_valid_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sms_oc_bus_arbiter.sv
// Testbench for sms_oc_bus_arbiter (default parameters: 4 requesters,
// settle 2, recover 1, max hold 16).
//
// The reference model describes each tenure by the edge numbers at which it
// was granted and released: oc_en is the owner's bit between grant and
// release, bus_valid is high from grant+SETTLE_CYCLES until release, busy is
// high until release+RECOVER_CYCLES. A compare process checks every output
// against it on each falling edge; directed tests add literal expectations.

module tb_sms_oc_bus_arbiter;

  localparam int N_REQ          = 4;
  localparam int SETTLE_CYCLES  = 2;
  localparam int RECOVER_CYCLES = 1;
  localparam int MAX_HOLD       = 16;
`ifdef SMS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic [N_REQ-1:0] req_n;
  logic [N_REQ-1:0] done_n;
  logic [N_REQ-1:0] oc_en;
  logic             bus_valid;
  logic             busy;
  logic [2:0]       owner;
  logic             timeout;

  int n_checks = 0;
  int n_fail   = 0;

  sms_oc_bus_arbiter #(
    .N_REQ          (N_REQ),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .RECOVER_CYCLES (RECOVER_CYCLES),
    .MAX_HOLD       (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_n     (req_n),
    .done_n    (done_n),
    .oc_en     (oc_en),
    .bus_valid (bus_valid),
    .busy      (busy),
    .owner     (owner),
    .timeout   (timeout)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset_n = 1'b0;
    req_n   = '1;
    done_n  = '1;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int edge_n    = 0;
  bit m_active  = 1'b0;
  bit m_released = 1'b0;
  int m_grant_e = 0;
  int m_rel_e   = 0;
  int m_owner   = 0;
  int m_ptr     = 0;
  bit m_to      = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active   = 1'b0;
      m_released = 1'b0;
      m_owner    = 0;
      m_ptr      = 0;
      m_to       = 1'b0;
    end else begin
      bit found;
      int pick;
      int own_start;
      bit forced;
      edge_n++;
      m_to  = 1'b0;
      found = 1'b0;
      pick  = 0;
      if (!m_active) begin
        for (int k = 0; k < N_REQ; k++) begin
          int idx;
          idx = (m_ptr + k) % N_REQ;
          if (!found && req_n[idx] === 1'b0) begin
            found = 1'b1;
            pick  = idx;
          end
        end
        if (found) begin
          m_active   = 1'b1;
          m_released = 1'b0;
          m_grant_e  = edge_n;
          m_owner    = pick;
          m_ptr      = (pick + 1) % N_REQ;
        end
      end else if (!m_released) begin
        own_start = m_grant_e + SETTLE_CYCLES;
        if (edge_n > own_start) begin
          forced = TO_EN && (edge_n == own_start + MAX_HOLD);
          if (done_n[m_owner] === 1'b0 || req_n[m_owner] !== 1'b0 || forced) begin
            m_released = 1'b1;
            m_rel_e    = edge_n;
            m_to       = forced;
          end
        end
      end else if (edge_n == m_rel_e + RECOVER_CYCLES) begin
        m_active = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0] e_oc;
    logic       e_bv;
    e_oc = (m_active && !m_released) ? 4'(1 << m_owner) : 4'b0000;
    e_bv = m_active && !m_released && (edge_n >= m_grant_e + SETTLE_CYCLES);
    chk("oc_en", 8'(oc_en), 8'(e_oc));
    chk("bus_valid", 8'(bus_valid), 8'(e_bv));
    chk("busy", 8'(busy), 8'(m_active));
    chk("owner", 8'(owner), 8'(m_owner));
    chk("timeout", 8'(timeout), 8'(m_to));
    chk("oc_en_onehot", 8'($countones(oc_en) <= 1), 8'd1);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    req_n   = 4'bzzzz;
    done_n  = '1;
    repeat (5) tick();
    req_n = 4'b1111;
    repeat (5) tick();
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_oc_en", 8'(oc_en), 8'd0);
    reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int w = 0; w < 30 && !got; w++) begin
      tick();
      if (busy === 1'b0) got = 1'b1;
    end
    chk("idle_reached", 8'(got), 8'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int order [5];
    bit got;
    order = '{0, 1, 2, 3, 0};

    // Basic tenure for requester 0.
    do_reset();
    req_n = 4'b1110;
    tick();                                      // edge 1
    chk("t2_oc_en_e1", 8'(oc_en), 8'h01);
    chk("t2_owner_e1", 8'(owner), 8'd0);
    chk("t2_busy_e1", 8'(busy), 8'd1);
    tick();                                      // edge 2
    chk("t2_bv_e2", 8'(bus_valid), 8'd0);
    tick();                                      // edge 3
    chk("t2_bv_e3", 8'(bus_valid), 8'd1);
    tick();
    tick();                                      // edge 5
    done_n = 4'b1110;
    tick();                                      // edge 6
    chk("t2_oc_en_e6", 8'(oc_en), 8'h00);
    chk("t2_bv_e6", 8'(bus_valid), 8'd0);
    chk("t2_busy_e6", 8'(busy), 8'd1);
    done_n = 4'b1111;
    req_n  = 4'b1111;
    tick();                                      // edge 7
    chk("t2_busy_e7", 8'(busy), 8'd0);

    // Round robin with all four requesting.
    do_reset();
    req_n = 4'b0000;
    for (int t = 0; t < 5; t++) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        tick();
        if (bus_valid === 1'b1) got = 1'b1;
      end
      chk("rr_bus_valid_seen", 8'(got), 8'd1);
      chk("rr_grant_order", 8'(owner), 8'(order[t]));
      tick();
      tick();
      done_n = ~(4'b0001 << order[t]);
      tick();
      done_n = 4'b1111;
    end
    req_n = 4'b1111;
    wait_idle();

    // Non-owner done_n is ignored; owner 2 then releases normally.
    do_reset();
    req_n = 4'b1011;
    tick();                                      // edge 1
    chk("nd_owner", 8'(owner), 8'd2);
    chk("nd_oc_en", 8'(oc_en), 8'h04);
    tick();
    tick();                                      // edge 3
    done_n = 4'b1101;
    repeat (3) tick();
    chk("nd_still_owned", 8'(oc_en), 8'h04);
    chk("nd_bv_held", 8'(bus_valid), 8'd1);
    done_n = 4'b1011;
    tick();
    chk("nd_released", 8'(oc_en), 8'h00);
    done_n = 4'b1111;
    req_n  = 4'b1111;
    tick();
    chk("nd_idle", 8'(busy), 8'd0);

    // Owner 2 abandons during SETTLE (pointer is at 3, wraps to 2).
    req_n = 4'b1011;
    tick();                                      // grant edge
    chk("ab_owner", 8'(owner), 8'd2);
    req_n = 4'b1111;
    tick();
    chk("ab_oc_en_settle", 8'(oc_en), 8'h04);
    tick();
    chk("ab_bv_one", 8'(bus_valid), 8'd1);
    tick();
    chk("ab_bv_zero", 8'(bus_valid), 8'd0);
    chk("ab_oc_en_rel", 8'(oc_en), 8'h00);
    chk("ab_busy_rel", 8'(busy), 8'd1);
    tick();
    chk("ab_idle", 8'(busy), 8'd0);

    // Long hold by requester 1.
    do_reset();
    req_n = 4'b1101;
    tick();                                      // edge 1
    chk("to_owner", 8'(owner), 8'd1);
`ifdef SMS_ARB_TIMEOUT_EN
    repeat (17) tick();                          // edge 18
    chk("to_held_e18", 8'(oc_en), 8'h02);
    chk("to_no_pulse_e18", 8'(timeout), 8'd0);
    tick();                                      // edge 19
    chk("to_pulse", 8'(timeout), 8'd1);
    chk("to_oc_en_off", 8'(oc_en), 8'h00);
    chk("to_owner_kept", 8'(owner), 8'd1);
    req_n = 4'b1111;
    tick();
    chk("to_pulse_end", 8'(timeout), 8'd0);
`else
    repeat (102) tick();
    chk("hold_still_owned", 8'(oc_en), 8'h02);
    chk("hold_bv", 8'(bus_valid), 8'd1);
    chk("hold_timeout", 8'(timeout), 8'd0);
    req_n = 4'b1111;
`endif
    wait_idle();

    // Asynchronous reset in the middle of OWN.
    do_reset();
    req_n = 4'b1001;
    tick();
    chk("ar_owner", 8'(owner), 8'd1);
    tick();
    tick();
    chk("ar_owned", 8'(bus_valid), 8'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_oc_en", 8'(oc_en), 8'h00);
    chk("ar_bv", 8'(bus_valid), 8'd0);
    chk("ar_busy", 8'(busy), 8'd0);
    chk("ar_owner_rst", 8'(owner), 8'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_first_grant", 8'(owner), 8'd1);
    chk("ar_first_oc_en", 8'(oc_en), 8'h02);
    req_n = 4'b1111;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
